// File: rtl/txstream_if.sv
// Stream port group between txstream_fifo (master) and the serial message encoder (slave).
// The encoder samples count/id when avail rises, then returns exactly count pulls.
interface txstream_if;
  logic [31:0] strm_data;
  logic [7:0]  strm_count;
  logic [3:0]  strm_id;
  logic        strm_avail;
  logic        strm_pull;

  modport master (
    output strm_data,
    output strm_count,
    output strm_id,
    output strm_avail,
    input  strm_pull
  );

  modport slave (
    input  strm_data,
    input  strm_count,
    input  strm_id,
    input  strm_avail,
    output strm_pull
  );
endinterface

// File: rtl/txstream_fifo.sv
// Sample FIFO framing messages for the stream encoder (threshold/flush; idle timeout under TXSTREAM_TIMEOUT_EN); push and trigger take 1 edge.
// No input backpressure: a push at full is dropped and sets sticky overflow; output drains only on strm_pull while a message is offered.
module txstream_fifo #(
  parameter int ADDR_W    = 6,
  parameter int STRM_ID   = 0,
  parameter int THRESHOLD = 16,
  parameter int MAX_COUNT = 32,
  parameter int TIMEOUT   = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     in_data,
  input  logic            in_valid,
  input  logic            flush,
  input  logic            ovf_clear,
  txstream_if.master      strm,
  output logic [ADDR_W:0] level,
  output logic            overflow
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] THR_L   = (ADDR_W + 1)'(THRESHOLD);
  localparam logic [ADDR_W:0] LVL_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [7:0]        rem_q, rem_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic              full;
  logic              push;
  logic              drop;
  logic              pop;
  logic              trigger;
  logic              tmo_fire;
  logic [7:0]        take;

  logic [31:0]       mem [DEPTH];

  assign full    = (level_q == DEPTH_L);
  assign push    = in_valid && !full;
  assign drop    = in_valid && full;
  assign pop     = strm.strm_pull && (state_q == ST_SEND);
  assign trigger = (state_q == ST_IDLE) && (level_q != '0) &&
                   ((level_q >= THR_L) || flush || tmo_fire);

`ifdef TXSTREAM_TIMEOUT_EN
  localparam int             TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_FIRE = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] timer_q, timer_d;

  // Counts idle cycles with data waiting; holds at the fire value (trigger leaves IDLE anyway).
  always_comb begin
    timer_d = timer_q;
    if ((level_q == '0) || (state_q != ST_IDLE)) begin
      timer_d = '0;
    end else if (timer_q != TMR_FIRE) begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  assign tmo_fire = (timer_q == TMR_FIRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    if (int'(level_q) > MAX_COUNT) begin
      take = 8'(MAX_COUNT);
    end else begin
      take = 8'(level_q);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !push) begin
      level_d = level_q - LVL_ONE;
    end

    // A drop wins over a simultaneous clear so no loss goes unreported.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clear) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_SEND;
          cnt_d   = take;
          rem_d   = take;
        end
      end
      ST_SEND: begin
        if (pop) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  assign strm.strm_data   = mem[rd_ptr_q];
  assign strm.strm_count  = cnt_q;
  assign strm.strm_id     = 4'(STRM_ID);
  assign strm.strm_avail  = (state_q == ST_SEND);
  assign level            = level_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_txstream_fifo.sv
// Directed scenarios plus a randomized run against a queue-based model of txstream_fifo.
module tb_txstream_fifo;
  localparam int ADDR_W     = 6;
  localparam int DEPTH      = 64;
  localparam int THRESHOLD  = 16;
  localparam int MAX_COUNT  = 32;
  localparam int TB_TIMEOUT = 100;
  localparam int TB_ID      = 10;

  logic            clk;
  logic            rst_n;
  logic [31:0]     in_data;
  logic            in_valid;
  logic            flush;
  logic            ovf_clear;
  logic [ADDR_W:0] level;
  logic            overflow;

  int total;
  int bad;

  txstream_if sif ();

  txstream_fifo #(
    .ADDR_W   (ADDR_W),
    .STRM_ID  (TB_ID),
    .THRESHOLD(THRESHOLD),
    .MAX_COUNT(MAX_COUNT),
    .TIMEOUT  (TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .flush    (flush),
    .ovf_clear(ovf_clear),
    .strm     (sif),
    .level    (level),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance one rising edge, return 1 time unit after it.
  task automatic cyc(input logic v, input logic [31:0] d, input logic p,
                     input logic f, input logic c);
    in_valid      = v;
    in_data       = d;
    sif.strm_pull = p;
    flush         = f;
    ovf_clear     = c;
    @(posedge clk);
    #1;
    in_valid      = 1'b0;
    sif.strm_pull = 1'b0;
    flush         = 1'b0;
    ovf_clear     = 1'b0;
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    flush         = 1'b0;
    ovf_clear     = 1'b0;
    sif.strm_pull = 1'b0;
    #12;
    total++; if (sif.strm_avail !== 1'b0) begin bad++; $display("FAIL reset_avail: got %0b want 0", sif.strm_avail); end
    total++; if (sif.strm_count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", sif.strm_count); end
    total++; if (level !== 7'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    total++; if (sif.strm_id !== 4'(TB_ID)) begin bad++; $display("FAIL reset_id: got %0d want %0d", sif.strm_id, TB_ID); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_threshold;
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h100 + i, 1'b0, 1'b0, 1'b0);
    total++; if (level !== 7'd16) begin bad++; $display("FAIL thr_level: got %0d want 16", level); end
    total++; if (sif.strm_avail !== 1'b0) begin bad++; $display("FAIL thr_avail_early: got %0b want 0", sif.strm_avail); end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    total++; if (sif.strm_avail !== 1'b1) begin bad++; $display("FAIL thr_avail: got %0b want 1", sif.strm_avail); end
    total++; if (sif.strm_count !== 8'd16) begin bad++; $display("FAIL thr_count: got %0d want 16", sif.strm_count); end
    for (int i = 0; i < 16; i++) begin
      total++; if (sif.strm_data !== 32'h100 + i) begin bad++; $display("FAIL thr_data[%0d]: got %h want %h", i, sif.strm_data, 32'h100 + i); end
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    total++; if (sif.strm_avail !== 1'b0) begin bad++; $display("FAIL thr_release: got %0b want 0", sif.strm_avail); end
    total++; if (level !== 7'd0) begin bad++; $display("FAIL thr_level_end: got %0d want 0", level); end
  endtask

  task automatic test_pull_idle;
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h500 + i, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++; if (level !== 7'd3) begin bad++; $display("FAIL idle_pull_level: got %0d want 3", level); end
    total++; if (sif.strm_data !== 32'h500) begin bad++; $display("FAIL idle_pull_data: got %h want 500", sif.strm_data); end
    total++; if (sif.strm_avail !== 1'b0) begin bad++; $display("FAIL idle_pull_avail: got %0b want 0", sif.strm_avail); end
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    total++; if (sif.strm_avail !== 1'b1) begin bad++; $display("FAIL flush_avail: got %0b want 1", sif.strm_avail); end
    total++; if (sif.strm_count !== 8'd3) begin bad++; $display("FAIL flush_count: got %0d want 3", sif.strm_count); end
    for (int i = 0; i < 3; i++) begin
      total++; if (sif.strm_data !== 32'h500 + i) begin bad++; $display("FAIL flush_data[%0d]: got %h want %h", i, sif.strm_data, 32'h500 + i); end
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    total++; if (sif.strm_avail !== 1'b0 || level !== 7'd0) begin bad++; $display("FAIL flush_end: avail %0b level %0d want 0/0", sif.strm_avail, level); end
  endtask

  task automatic test_overflow_clamp;
    for (int i = 0; i < 64; i++) cyc(1'b1, 32'h200 + i, 1'b0, 1'b0, 1'b0);
    total++; if (level !== 7'd64) begin bad++; $display("FAIL full_level: got %0d want 64", level); end
    total++; if (sif.strm_avail !== 1'b1 || sif.strm_count !== 8'd16) begin bad++; $display("FAIL full_msg: avail %0b count %0d want 1/16", sif.strm_avail, sif.strm_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_no_ovf: got %0b want 0", overflow); end
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    total++; if (level !== 7'd64 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_drop: level %0d ovf %0b want 64/1", level, overflow); end
    cyc(1'b1, 32'hDEAE, 1'b1, 1'b0, 1'b0);
    total++; if (level !== 7'd63) begin bad++; $display("FAIL ovf_pull_drop_level: got %0d want 63", level); end
    total++; if (sif.strm_data !== 32'h201) begin bad++; $display("FAIL ovf_pull_data: got %h want 201", sif.strm_data); end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %0b want 0", overflow); end
    cyc(1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAF, 1'b0, 1'b0, 1'b1);
    total++; if (overflow !== 1'b1 || level !== 7'd64) begin bad++; $display("FAIL ovf_drop_vs_clear: ovf %0b level %0d want 1/64", overflow, level); end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 16; i++) begin
      total++; if (sif.strm_data !== 32'h200 + i) begin bad++; $display("FAIL msg16_data[%0d]: got %h want %h", i, sif.strm_data, 32'h200 + i); end
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    total++; if (sif.strm_avail !== 1'b0 || level !== 7'd49) begin bad++; $display("FAIL msg16_release: avail %0b level %0d want 0/49", sif.strm_avail, level); end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    total++; if (sif.strm_avail !== 1'b1 || sif.strm_count !== 8'd32) begin bad++; $display("FAIL clamp_count: avail %0b count %0d want 1/32", sif.strm_avail, sif.strm_count); end
    for (int i = 0; i < 32; i++) begin
      total++; if (sif.strm_data !== 32'h210 + i) begin bad++; $display("FAIL clamp_data[%0d]: got %h want %h", i, sif.strm_data, 32'h210 + i); end
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    total++; if (sif.strm_avail !== 1'b0 || level !== 7'd17) begin bad++; $display("FAIL clamp_release: avail %0b level %0d want 0/17", sif.strm_avail, level); end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    total++; if (sif.strm_avail !== 1'b1 || sif.strm_count !== 8'd17) begin bad++; $display("FAIL rest_count: avail %0b count %0d want 1/17", sif.strm_avail, sif.strm_count); end
    for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++; if (sif.strm_data !== 32'hBEEF) begin bad++; $display("FAIL rest_last_data: got %h want beef", sif.strm_data); end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++; if (sif.strm_avail !== 1'b0 || level !== 7'd0) begin bad++; $display("FAIL rest_end: avail %0b level %0d want 0/0", sif.strm_avail, level); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 65; i++) cyc(1'b1, 32'h300 + i, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++; if (sif.strm_avail !== 1'b1 || overflow !== 1'b1 || level !== 7'd59) begin bad++; $display("FAIL pre_reset: avail %0b ovf %0b level %0d want 1/1/59", sif.strm_avail, overflow, level); end
    rst_n = 1'b0;
    #2;
    total++; if (sif.strm_avail !== 1'b0 || sif.strm_count !== 8'd0) begin bad++; $display("FAIL midrst_msg: avail %0b count %0d want 0/0", sif.strm_avail, sif.strm_count); end
    total++; if (level !== 7'd0 || overflow !== 1'b0) begin bad++; $display("FAIL midrst_state: level %0d ovf %0b want 0/0", level, overflow); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    total++; if (sif.strm_data !== 32'h400 || level !== 7'd1) begin bad++; $display("FAIL postrst_push: data %h level %0d want 400/1", sif.strm_data, level); end
    cyc(1'b1, 32'h401, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    total++; if (sif.strm_count !== 8'd2) begin bad++; $display("FAIL postrst_count: got %0d want 2", sif.strm_count); end
    for (int i = 0; i < 2; i++) begin
      total++; if (sif.strm_data !== 32'h400 + i) begin bad++; $display("FAIL postrst_data[%0d]: got %h want %h", i, sif.strm_data, 32'h400 + i); end
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    total++; if (sif.strm_avail !== 1'b0) begin bad++; $display("FAIL postrst_release: got %0b want 0", sif.strm_avail); end
  endtask

  task automatic test_timeout;
    int early;
    early = 0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h600 + i, 1'b0, 1'b0, 1'b0);
`ifdef TXSTREAM_TIMEOUT_EN
    for (int k = 3; k < TB_TIMEOUT; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (sif.strm_avail !== 1'b0) early++;
    end
    total++; if (early != 0) begin bad++; $display("FAIL tmo_early: avail high in %0d cycles want 0", early); end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    total++; if (sif.strm_avail !== 1'b1 || sif.strm_count !== 8'd3) begin bad++; $display("FAIL tmo_fire: avail %0b count %0d want 1/3", sif.strm_avail, sif.strm_count); end
`else
    for (int k = 0; k < 10000; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (sif.strm_avail !== 1'b0) early++;
    end
    total++; if (early != 0) begin bad++; $display("FAIL no_tmo: avail high in %0d cycles want 0", early); end
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
`endif
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++; if (sif.strm_avail !== 1'b0 || level !== 7'd0) begin bad++; $display("FAIL tmo_drain: avail %0b level %0d want 0/0", sif.strm_avail, level); end
  endtask

  task automatic test_random;
    logic [31:0] q[$];
    bit          send;
    int          mcnt;
    int          rem;
    bit          ovf;
    int          idle_age;
    int          push_pct;
    logic        v, p, f, c;
    logic [31:0] d;
    bit          pop, trig, tmo;
    int          size;

    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send = 0; mcnt = 0; rem = 0; ovf = 0; idle_age = 0; push_pct = 50;

    for (int n = 0; n < 4000; n++) begin
      if (n % 400 == 0) push_pct = $urandom_range(20, 90);
      v = ($urandom_range(0, 99) < push_pct);
      d = $urandom;
      p = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 99) < 3);
      c = ($urandom_range(0, 99) < 5);

      size = q.size();
      pop  = p && send;
`ifdef TXSTREAM_TIMEOUT_EN
      tmo  = (idle_age == TB_TIMEOUT - 1);
`else
      tmo  = 1'b0;
`endif
      trig = !send && size != 0 && (size >= THRESHOLD || f || tmo);

      cyc(v, d, p, f, c);

      if (size == 0 || send) idle_age = 0;
      else idle_age++;
      if (trig) begin
        send = 1;
        mcnt = (size > MAX_COUNT) ? MAX_COUNT : size;
        rem  = mcnt;
      end else if (pop) begin
        rem--;
        if (rem == 0) send = 0;
      end
      if (pop) void'(q.pop_front());
      if (v && size < DEPTH) q.push_back(d);
      if (v && size == DEPTH) ovf = 1;
      else if (c) ovf = 0;

      total++; if (sif.strm_avail !== send) begin bad++; $display("FAIL rnd_avail@%0d: got %0b want %0b", n, sif.strm_avail, send); end
      total++; if (level !== (ADDR_W + 1)'(q.size())) begin bad++; $display("FAIL rnd_level@%0d: got %0d want %0d", n, level, q.size()); end
      total++; if (overflow !== ovf) begin bad++; $display("FAIL rnd_ovf@%0d: got %0b want %0b", n, overflow, ovf); end
      if (send) begin
        total++; if (sif.strm_count !== 8'(mcnt)) begin bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, sif.strm_count, mcnt); end
      end
      if (q.size() != 0) begin
        total++; if (sif.strm_data !== q[0]) begin bad++; $display("FAIL rnd_data@%0d: got %h want %h", n, sif.strm_data, q[0]); end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_threshold();
    test_pull_idle();
    test_overflow_clamp();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/txstream_fifo.md
# txstream_fifo

Buffers 32-bit sample words from a single producer and presents them as one framed data stream to the serial message encoder. Decides when a message is sent (fill threshold, explicit flush or idle timeout) and how many words it carries. Sits directly upstream of the encoder and drives its `strm_*` port group: the encoder samples `strm_count`/`strm_id` once when it accepts a stream, then issues exactly `strm_count` pulls.

## Interface
- `ADDR_W`, 6: FIFO depth D = 2^ADDR_W words.
- `STRM_ID`, 0: 4-bit stream id placed on `strm_id`.
- `THRESHOLD`, 16: fill level that triggers a message. Legal range 1..D.
- `MAX_COUNT`, 32: maximum words per message. Legal range 1..min(255, D).
- `TIMEOUT`, 1000: idle-cycle flush timeout. Minimum 2. Used only with `TXSTREAM_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  32  sample word.
- `in_valid`  in  1  push strobe; no backpressure.
- `flush`  in  1  level-sensitive request to send buffered words now.
- `ovf_clear`  in  1  clears `overflow`.
- `strm_data`  out  32  head-of-FIFO word (show-ahead).
- `strm_count`  out  8  words in the offered message.
- `strm_id`  out  4  constant `STRM_ID`.
- `strm_avail`  out  1  message offered.
- `strm_pull`  in  1  consume head word.
- `level`  out  ADDR_W+1  current occupancy, 0..D.
- `overflow`  out  1  sticky flag: a word was dropped.

## Operation
- **FIFO.** Circular buffer with ADDR_W-bit read/write pointers plus an (ADDR_W+1)-bit occupancy counter. Memory contents are not reset.
  - `strm_data` = mem[rd_ptr] combinationally. Its value is don't-care when empty.
- **Push.** Accepted when `in_valid` and level < D. When full, the word is dropped and `overflow` is set. This also applies when a pull occurs in the same cycle: no pass-through at full.
- **Pop.** Occurs when `strm_pull` and state is SEND. A pull while IDLE is ignored and pops nothing.
- **Simultaneous push and pop when not full:** level is unchanged and both pointers advance.
- **State machine.**
  - IDLE → SEND on trigger. On entry: remaining = msg_count = min(level, MAX_COUNT), using the registered level before this cycle's push/pop.
  - SEND: remaining decrements on each pop. Returns to IDLE on the edge that performs the pop with remaining == 1.
  - Trigger, evaluated only in IDLE with level ≠ 0: level ≥ THRESHOLD, or `flush`, or timeout fired.
- **Outputs.** `strm_avail` = (state == SEND). `strm_count` = msg_count, stable for the whole SEND state and never 0 while avail.
- **After SEND.** The block may re-trigger immediately while the encoder is still transmitting its CRC/terminator. This is safe because occupancy only grows until the next pull.
- **`overflow`.** Sticky. `ovf_clear` clears it. If a drop and a clear happen in the same cycle, the flag ends up set.
- **Reset.** Asserting `rst_n` low at any time, including mid-message, immediately forces:
  - state IDLE, pointers 0, `level` 0, `strm_avail` 0, `strm_count` 0, `overflow` 0, timer 0.
  - `strm_id` = STRM_ID.

## Timing
- Push latency: a word accepted at edge E is visible in `level` after E. If the FIFO was empty, it is also on `strm_data` after E.
- Trigger to avail: if the condition is true in the cycle before edge E, `strm_avail` and `strm_count` are valid after E.
- Pop: `strm_data` advances to the next word after the pulling edge.
- Release: `strm_avail` falls after the edge of the final pull. The earliest re-assert is one edge later.
- Timer (only with `TXSTREAM_TIMEOUT_EN`):
  - Resets to 0 whenever level == 0 or state ≠ IDLE; otherwise increments by 1 per cycle, saturating.
  - Fires when timer == TIMEOUT−1. For words pushed into an empty IDLE FIFO at edge E0, `strm_avail` rises at edge E0+TIMEOUT if no other trigger fires first.
  - Further pushes do not reset the timer.

## Configuration
- **`TXSTREAM_TIMEOUT_EN` defined:** timeout counter and trigger are present.
- **Undefined:** no timer logic. Messages trigger only on THRESHOLD or `flush`, and a partially filled FIFO below THRESHOLD waits indefinitely. `TIMEOUT` is ignored.

## Test plan
- **Threshold trigger.** THRESHOLD=16: push words 0x100..0x10F, one per cycle.
  - `strm_avail`=1 and `strm_count`=16 one edge after the 16th push.
  - 16 pulls return 0x100..0x10F in order; avail drops after the 16th pull; level=0.
- **Count clamp.** THRESHOLD=64, MAX_COUNT=32: push 40 words, then pulse `flush`.
  - `strm_count`=32; after 32 pulls avail drops.
  - The next trigger (flush held) gives `strm_count`=8.
- **Timeout.** TIMEOUT=100, macro defined: push 3 words at E0..E2.
  - `strm_avail` rises at E100 with `strm_count`=3.
  - With the macro undefined, avail stays 0 for 10000 cycles.
- **Overflow.** Fill 64 words with no pulls, push 0xDEAD.
  - Word dropped, `level`=64, `overflow`=1.
  - A push at full coinciding with a pull is also dropped.
  - `ovf_clear` returns `overflow` to 0.
- **Pull while idle.** A pull with `strm_avail`=0 leaves `level`, `strm_data` and the pointers unchanged.
- **Reset mid-message.** During SEND after 5 of 16 pulls, pulse `rst_n` low.
  - Outputs immediately go to `strm_avail`=0, `strm_count`=0, `level`=0, `overflow`=0.
  - New pushes after release start from rd/wr pointer 0.
